// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to a variable-latency
// instruction memory and presents instr_o/pc_o to decode, with a 1-entry hold buffer for stalls.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_en_i,
    input  logic        if_en_i,
    input  logic        flush_i,
    input  logic        pc_src_i,
    input  logic [63:0] branch_pc_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic        instr_valid_o
);

    localparam logic [1:0] REQ  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] KILL = 2'd2;

    logic [1:0]  state_r;
    logic [63:0] pc_r;
    logic [63:0] req_pc_r;
    logic        buf_full_r;
    logic [31:0] buf_instr_r;
    logic [63:0] buf_pc_r;

    logic grant;
    logic rsp;

    // A full hold buffer blocks new fetches so at most one word ever needs parking.
    assign imem_req_o  = ~rst_i & (state_r == REQ) & pc_en_i & ~buf_full_r;
    assign imem_addr_o = pc_r;
    assign grant       = imem_req_o & imem_gnt_i;
    assign rsp         = (state_r == WAIT) & imem_rvalid_i;

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (state_r == WAIT || state_r == KILL) begin
                state_r <= KILL;
            end else begin
                state_r <= REQ;
            end
            pc_r          <= RESET_PC;
            req_pc_r      <= 64'h0;
            buf_full_r    <= 1'b0;
            instr_o       <= NOP_INSTR;
            pc_o          <= 64'h0;
            instr_valid_o <= 1'b0;
        end else begin
            case (state_r)
                REQ: begin
                    if (grant) begin
                        state_r <= pc_src_i ? KILL : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_r <= REQ;
                    end else if (pc_src_i) begin
                        state_r <= KILL;
                    end
                end
                KILL: begin
                    if (imem_rvalid_i) begin
                        state_r <= REQ;
                    end
                end
                default: state_r <= REQ;
            endcase

            if (pc_src_i) begin
                pc_r <= branch_pc_i;
            end else if (grant) begin
                pc_r <= pc_r + 64'd4;
            end

            if (grant) begin
                req_pc_r <= pc_r;
            end

            if (pc_src_i) begin
                buf_full_r <= 1'b0;
            end else if (if_en_i && buf_full_r) begin
                buf_full_r <= 1'b0;
            end else if (rsp && !if_en_i) begin
                buf_full_r <= 1'b1;
            end

            // A flush squashes whatever would have been presented; pc_o keeps its last value.
            if (if_en_i) begin
                if (flush_i || pc_src_i) begin
                    instr_o       <= NOP_INSTR;
                    instr_valid_o <= 1'b0;
                end else if (buf_full_r) begin
                    instr_o       <= buf_instr_r;
                    pc_o          <= buf_pc_r;
                    instr_valid_o <= 1'b1;
                end else if (rsp) begin
                    instr_o       <= imem_rdata_i;
                    pc_o          <= req_pc_r;
                    instr_valid_o <= 1'b1;
                end else begin
                    instr_o       <= NOP_INSTR;
                    instr_valid_o <= 1'b0;
                end
            end else if (flush_i) begin
                instr_o       <= NOP_INSTR;
                instr_valid_o <= 1'b0;
            end
        end
    end

    // NOTE: the buffer payload has no reset; buf_full_r alone says whether it is meaningful.
    always_ff @(posedge clk_i) begin
        if (!rst_i && rsp && !if_en_i && !pc_src_i) begin
            buf_instr_r <= imem_rdata_i;
            buf_pc_r    <= req_pc_r;
        end
    end

endmodule
